fft_frame_sequencer: RTL

- Run controller sitting between the multichannel sample source and the sample interleaver / FFT input.
- On a start pulse it issues one FFT configuration word, then passes exactly frame_count frames of FRAME_LEN beats from source to sink.
- It drives tlast on each frame boundary and zero-pads a frame that the source terminates early.
- Gates the datapath: no sample moves outside an armed run.

---
 rtl/fft_frame_sequencer.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer
//   Run controller between the multichannel sample source and the FFT input
//   (via the sample interleaver). A start pulse arms a run: one FFT config
//   word is issued, then frame_count frames of 2**FRAME_LEN_LOG2 beats are
//   passed from source to sink with tlast on every frame boundary. A frame
//   the source ends early (source tlast) is completed with zero beats.
//   Outside an armed run the datapath is closed.
//
// Optional feature macro: FFT_SEQ_ABORT_EN
//   When defined, an 'abort' input is added. Abort in CONFIG drops the run.
//   Abort in STREAM finishes the current frame with zero padding, unless no
//   beat of the frame has moved yet, in which case the run ends at once.
//
// Ports
//   aclk, areset            clock, asynchronous active-high reset
//   start, frame_count      run arm pulse and frames per run (0 = until tlast)
//   abort                   (FFT_SEQ_ABORT_EN only) stop current run
//   s_axis_simple_*         source sample stream (tdata/tvalid/tready/tlast)
//   m_axis_simple_*         sink sample stream (tdata/tvalid/tready/tlast)
//   m_axis_config_*         FFT configuration word channel
//   busy                    run in progress
//   frames_done             frames completed in the current/last run
//   short_frame             sticky: a frame of this run was zero-padded

module fft_frame_sequencer #(
  parameter int                      CHANNEL_WIDTH  = 16,
  parameter int                      CHANNELS       = 8,
  parameter int                      DATA_WIDTH     = CHANNEL_WIDTH * CHANNELS,
  parameter int                      FRAME_LEN_LOG2 = 10,
  parameter int                      CONFIG_WIDTH   = 16,
  parameter logic [CONFIG_WIDTH-1:0] CONFIG_WORD    = 16'h0001
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    start,
  input  logic [15:0]             frame_count,
`ifdef FFT_SEQ_ABORT_EN
  input  logic                    abort,
`endif
  input  logic [DATA_WIDTH-1:0]   s_axis_simple_tdata,
  input  logic                    s_axis_simple_tvalid,
  output logic                    s_axis_simple_tready,
  input  logic                    s_axis_simple_tlast,
  output logic [DATA_WIDTH-1:0]   m_axis_simple_tdata,
  output logic                    m_axis_simple_tvalid,
  input  logic                    m_axis_simple_tready,
  output logic                    m_axis_simple_tlast,
  output logic [CONFIG_WIDTH-1:0] m_axis_config_tdata,
  output logic                    m_axis_config_tvalid,
  input  logic                    m_axis_config_tready,
  output logic                    busy,
  output logic [15:0]             frames_done,
  output logic                    short_frame
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONFIG = 2'd1,
    ST_STREAM = 2'd2,
    ST_PAD    = 2'd3
  } state_t;

  localparam logic [FRAME_LEN_LOG2-1:0] LAST_BEAT = {FRAME_LEN_LOG2{1'b1}};
  localparam logic [FRAME_LEN_LOG2-1:0] BEAT_ZERO = {FRAME_LEN_LOG2{1'b0}};
  localparam logic [FRAME_LEN_LOG2-1:0] BEAT_ONE  = {{(FRAME_LEN_LOG2-1){1'b0}}, 1'b1};

  state_t                    state_r, state_nxt_s;
  logic [FRAME_LEN_LOG2-1:0] beat_r, beat_nxt_s;
  logic [15:0]               frames_done_r, frames_nxt_s;
  logic [15:0]               count_r, count_nxt_s;
  logic                      short_r, short_nxt_s;
  logic                      abort_s;
  logic                      at_last_s;
  logic                      s_hs_s;
  logic                      count_done_s;
  logic [15:0]               frames_inc_s;

`ifdef FFT_SEQ_ABORT_EN
  assign abort_s = abort;
`else
  assign abort_s = 1'b0;
`endif

  assign at_last_s    = (beat_r == LAST_BEAT);
  assign s_hs_s       = s_axis_simple_tvalid && m_axis_simple_tready;
  // Saturating frame counter increment.
  assign frames_inc_s = (frames_done_r == 16'hFFFF) ? frames_done_r : frames_done_r + 16'd1;
  // Compared one bit wider so a saturated counter cannot alias a count of 0.
  assign count_done_s = (count_r != 16'd0) &&
                        (({1'b0, frames_done_r} + 17'd1) == {1'b0, count_r});

  assign frames_done  = frames_done_r;
  assign short_frame  = short_r;

  // Next-state, counter updates and all stream/config outputs.
  always_comb begin
    state_nxt_s          = state_r;
    beat_nxt_s           = beat_r;
    frames_nxt_s         = frames_done_r;
    count_nxt_s          = count_r;
    short_nxt_s          = short_r;
    s_axis_simple_tready = 1'b0;
    m_axis_simple_tdata  = {DATA_WIDTH{1'b0}};
    m_axis_simple_tvalid = 1'b0;
    m_axis_simple_tlast  = 1'b0;
    m_axis_config_tdata  = {CONFIG_WIDTH{1'b0}};
    m_axis_config_tvalid = 1'b0;
    busy                 = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (start) begin
          count_nxt_s  = frame_count;
          frames_nxt_s = 16'd0;
          short_nxt_s  = 1'b0;
          beat_nxt_s   = BEAT_ZERO;
          state_nxt_s  = ST_CONFIG;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end

      ST_CONFIG: begin
        busy = 1'b1;
        if (abort_s) begin
          // Config offer is withdrawn in the abort cycle itself.
          state_nxt_s = ST_IDLE;
        end else begin
          m_axis_config_tvalid = 1'b1;
          m_axis_config_tdata  = CONFIG_WORD;
          if (m_axis_config_tready) begin
            beat_nxt_s  = BEAT_ZERO;
            state_nxt_s = ST_STREAM;
          end else begin
            state_nxt_s = ST_CONFIG;
          end
        end
      end

      ST_STREAM: begin
        busy                 = 1'b1;
        m_axis_simple_tdata  = s_axis_simple_tdata;
        m_axis_simple_tvalid = s_axis_simple_tvalid;
        s_axis_simple_tready = m_axis_simple_tready;
        m_axis_simple_tlast  = at_last_s;
        if (s_hs_s) begin
          if (at_last_s) begin
            // Frame complete: an abort here has nothing left to pad.
            beat_nxt_s   = BEAT_ZERO;
            frames_nxt_s = frames_inc_s;
            if (count_done_s || s_axis_simple_tlast || abort_s) begin
              state_nxt_s = ST_IDLE;
            end else begin
              state_nxt_s = ST_STREAM;
            end
          end else begin
            beat_nxt_s = beat_r + BEAT_ONE;
            if (s_axis_simple_tlast || abort_s) begin
              short_nxt_s = 1'b1;
              state_nxt_s = ST_PAD;
            end else begin
              state_nxt_s = ST_STREAM;
            end
          end
        end else if (abort_s) begin
          // Abort before the first beat of a frame leaves nothing to finish.
          if (beat_r == BEAT_ZERO) begin
            state_nxt_s = ST_IDLE;
          end else begin
            short_nxt_s = 1'b1;
            state_nxt_s = ST_PAD;
          end
        end else begin
          state_nxt_s = ST_STREAM;
        end
      end

      ST_PAD: begin
        busy                 = 1'b1;
        m_axis_simple_tvalid = 1'b1;
        m_axis_simple_tlast  = at_last_s;
        if (m_axis_simple_tready) begin
          if (at_last_s) begin
            beat_nxt_s   = BEAT_ZERO;
            frames_nxt_s = frames_inc_s;
            state_nxt_s  = ST_IDLE;
          end else begin
            beat_nxt_s  = beat_r + BEAT_ONE;
            state_nxt_s = ST_PAD;
          end
        end else begin
          state_nxt_s = ST_PAD;
        end
      end

      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, beat counter, run count latch and status registers.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_r       <= ST_IDLE;
      beat_r        <= BEAT_ZERO;
      frames_done_r <= 16'd0;
      count_r       <= 16'd0;
      short_r       <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      beat_r        <= beat_nxt_s;
      frames_done_r <= frames_nxt_s;
      count_r       <= count_nxt_s;
      short_r       <= short_nxt_s;
    end
  end

endmodule
